// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way, 8-set, 256-bit-line write-back cache: hit check,
// dirty-victim writeback, line allocation. Optional counters: CACHE_CTRL_PERF_CNT_EN.
module cache_control (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [1:0]       hit,
   input  logic             lru_out,
   input  logic [1:0]       dirty_out,
   input  logic [1:0]       valid_out,
   input  logic             pmem_resp,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic             arrays_read,
   output logic [1:0]       tag_load,
   output logic [1:0]       valid_load,
   output logic [1:0]       valid_in,
   output logic [1:0]       dirty_load,
   output logic [1:0]       dirty_in,
   output logic [1:0]       data_array_mux_sel,
   output logic [1:0][1:0]  mem_mask_mux_sel,
   output logic             pmem_addr_mux_sel,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count,
   output logic [31:0]      wb_count
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WRITEBACK,
      ALLOCATE,
      RELOAD
   } state_t;

   state_t state_reg, state_next;
   logic   victim_reg, victim_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         victim_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         victim_reg <= victim_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      victim_next        = victim_reg;
      mem_resp           = 1'b0;
      pmem_read          = 1'b0;
      pmem_write         = 1'b0;
      arrays_read        = 1'b0;
      tag_load           = 2'b00;
      valid_load         = 2'b00;
      valid_in           = 2'b00;
      dirty_load         = 2'b00;
      dirty_in           = 2'b00;
      data_array_mux_sel = 2'b00;
      mem_mask_mux_sel   = '0;
      pmem_addr_mux_sel  = 1'b0;
      // Outputs are forced low while reset is held, even with a request pending.
      if (!rst) begin
         unique case (state_reg)
            IDLE: begin
               if (mem_read || mem_write) begin
                  arrays_read = 1'b1;
                  state_next  = CHECK;
               end
            end
            CHECK: begin
               if (|hit) begin
                  mem_resp   = 1'b1;
                  state_next = IDLE;
                  if (mem_write) begin
                     // Way 0 wins when both ways report a hit.
                     data_array_mux_sel[~hit[0]] = 1'b1;
                     mem_mask_mux_sel[~hit[0]]   = 2'd2;
                     dirty_load[~hit[0]]         = 1'b1;
                     dirty_in[~hit[0]]           = 1'b1;
                  end
               end else begin
                  victim_next = lru_out;
                  if (valid_out[lru_out] && dirty_out[lru_out])
                     state_next = WRITEBACK;
                  else
                     state_next = ALLOCATE;
               end
            end
            WRITEBACK: begin
               pmem_addr_mux_sel = 1'b1;
               pmem_write        = 1'b1;
               if (pmem_resp)
                  state_next = ALLOCATE;
            end
            ALLOCATE: begin
               pmem_read = 1'b1;
               if (pmem_resp) begin
                  mem_mask_mux_sel[victim_reg] = 2'd1;
                  tag_load[victim_reg]         = 1'b1;
                  valid_load[victim_reg]       = 1'b1;
                  valid_in[victim_reg]         = 1'b1;
                  dirty_load[victim_reg]       = 1'b1;
                  state_next                   = RELOAD;
               end
            end
            RELOAD: begin
               arrays_read = 1'b1;
               state_next  = CHECK;
            end
            default: state_next = IDLE;
         endcase
      end
   end

`ifdef CACHE_CTRL_PERF_CNT_EN
   logic in_check;
   assign in_check = (state_reg == CHECK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (in_check && (|hit))
            hit_count <= hit_count + 32'd1;
         if (in_check && !(|hit))
            miss_count <= miss_count + 32'd1;
         if (in_check && !(|hit) && valid_out[lru_out] && dirty_out[lru_out])
            wb_count <= wb_count + 32'd1;
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
   assign wb_count   = '0;
`endif

endmodule
